// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection, stall/bubble steering, run/halt
// sequencing and performance counters for the 5-stage pipe.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic             running,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [3:0] R_NONE   = 4'd15;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cpu_stat_q, cpu_stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic load_use_s, ret_pend_s, mispred_s, exc_m_s, exc_w_s, retire_s;

    assign load_use_s = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                        (E_dstM != R_NONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend_s = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred_s  = (E_icode == I_JXX) && !e_Cnd;
    assign exc_m_s    = (m_stat != S_AOK);
    assign exc_w_s    = (W_stat != S_AOK);
    assign retire_s   = (W_stat == S_AOK) && (W_icode != I_NOP);

    // Next-state, pipeline controls and counter updates per run state
    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        retired_d  = retired_q;
        stall_d    = stall_q;
        mispred_d  = mispred_q;
        F_stall    = 1'b1;
        D_stall    = 1'b0;
        D_bubble   = 1'b1;
        E_bubble   = 1'b1;
        M_bubble   = 1'b1;
        W_stall    = 1'b0;
        set_cc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // D_stall wins over the ret bubble so a held D is never also flushed
                F_stall  = load_use_s | ret_pend_s;
                D_stall  = load_use_s;
                D_bubble = mispred_s | (ret_pend_s & !load_use_s);
                E_bubble = mispred_s | load_use_s;
                M_bubble = exc_m_s | exc_w_s;
                W_stall  = exc_w_s;
                set_cc   = (E_icode == I_OPQ) && !exc_m_s && !exc_w_s;
                if (retire_s) begin
                    retired_d = retired_q + CNT_ONE;
                end else begin
                    retired_d = retired_q;
                end
                if (load_use_s | ret_pend_s) begin
                    stall_d = stall_q + CNT_ONE;
                end else begin
                    stall_d = stall_q;
                end
                if (mispred_s) begin
                    mispred_d = mispred_q + CNT_ONE;
                end else begin
                    mispred_d = mispred_q;
                end
                if (exc_w_s) begin
                    state_d    = ST_HALT;
                    cpu_stat_d = W_stat;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
                set_cc   = 1'b0;
                state_d  = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, status and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cpu_stat_q <= S_AOK;
            retired_q  <= CNT_ZERO;
            stall_q    <= CNT_ZERO;
            mispred_q  <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
            retired_q  <= retired_d;
            stall_q    <= stall_d;
            mispred_q  <= mispred_d;
        end
    end

    assign cpu_stat    = cpu_stat_q;
    assign running     = (state_q == ST_RUN);
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
    assign mispred_cnt = mispred_q;

endmodule
